// File: rtl/ysyx_lsu_ctrl_pkg.sv
// Shared LSU constants: FSM states, RV32 funct3 codes, strobes.
// Also holds the access-fault check used at request capture.
package ysyx_lsu_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0f;

  function automatic logic [7:0] strb_of(
    input logic [1:0] sz
  );
    logic [7:0] s;
    s = STRB_B;
    unique case (1'b1)
      (sz == 2'b01): s = STRB_H;
      (sz == 2'b10): s = STRB_W;
      default:       s = STRB_B;
    endcase
    return s;
  endfunction

  function automatic logic is_fault(
    input logic       ren,
    input logic       wen,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ld_ok;
    logic st_ok;
    logic mis;
    ld_ok = (f3 == F3_B) || (f3 == F3_H)
         || (f3 == F3_W) || (f3 == F3_BU)
         || (f3 == F3_HU);
    st_ok = (f3 == F3_B) || (f3 == F3_H)
         || (f3 == F3_W);
    mis = ((f3[1:0] == 2'b01) && off[0])
       || ((f3[1:0] == 2'b10) && (off != 2'b00));
    if (ren && wen)
      return 1'b1;
    if (ren)
      return !ld_ok || mis;
    if (wen)
      return !st_ok || mis;
    return 1'b0;
  endfunction

endpackage

// File: rtl/ysyx_lsu_ext.sv
// Load data alignment and sign/zero extension.
// Purely combinational; shifts the bus word down to lane 0.
module ysyx_lsu_ext
  import ysyx_lsu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        f3,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] sh;

  // Align selected lane to bit 0, then extend by size/sign
  always_comb begin
    sh = rdata >> {off, 3'b000};
    data = sh;
    unique case (1'b1)
      (f3 == F3_B):
        data = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      (f3 == F3_H):
        data = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      (f3 == F3_BU):
        data = {{(DATA_W-8){1'b0}}, sh[7:0]};
      (f3 == F3_HU):
        data = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default:
        data = sh;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu_ctrl.sv
// LSU control: one outstanding load or store at a time.
// Captures the EXU request, drives the arbiter, returns to WBU.
module ysyx_lsu_ctrl
  import ysyx_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  output logic              out_valid_o,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata_o,
  output logic [4:0]        out_rd_o,
  output logic              out_fault_o,
  output logic [ADDR_W-1:0] lsu_araddr_o,
  output logic              lsu_arvalid_o,
  output logic [7:0]        lsu_rstrb_o,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rvalid,
  output logic [ADDR_W-1:0] lsu_awaddr_o,
  output logic              lsu_awvalid_o,
  output logic [DATA_W-1:0] lsu_wdata_o,
  output logic [7:0]        lsu_wstrb_o,
  output logic              lsu_wvalid_o,
  input  logic              lsu_wready
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ext_data;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              fault_q;
  logic              fault_in;

  assign fault_in = is_fault(in_ren, in_wen,
                             in_funct3,
                             in_addr[1:0]);

  ysyx_lsu_ext #(
    .DATA_W(DATA_W)
  ) u_ext (
    .rdata(lsu_rdata),
    .off  (addr_q[1:0]),
    .f3   (f3_q),
    .data (ext_data)
  );

  // Request capture, bus wait and WBU handshake sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            f3_q    <= in_funct3;
            rd_q    <= in_rd;
            fault_q <= fault_in;
            rdata_q <= '0;
            if (fault_in)
              state <= S_RESP;
            else if (in_ren)
              state <= S_RD;
            else if (in_wen)
              state <= S_WR;
            else
              state <= S_RESP;
          end
        end
        S_RD: begin
          if (lsu_rvalid) begin
            rdata_q <= ext_data;
            state   <= S_RESP;
          end
        end
        S_WR: begin
          if (lsu_wready)
            state <= S_RESP;
        end
        S_RESP: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o    = (state == S_IDLE) && !rst;
  assign out_valid_o   = (state == S_RESP);
  assign out_rdata_o   = rdata_q;
  assign out_rd_o      = rd_q;
  assign out_fault_o   = fault_q;

  assign lsu_araddr_o  = addr_q;
  assign lsu_arvalid_o = (state == S_RD);
  assign lsu_rstrb_o   = strb_of(f3_q[1:0]);

  assign lsu_awaddr_o  = addr_q;
  assign lsu_awvalid_o = (state == S_WR);
  assign lsu_wvalid_o  = (state == S_WR);
  assign lsu_wdata_o   = wdata_q;
  assign lsu_wstrb_o   = strb_of(f3_q[1:0]);

endmodule

// File: tb/tb_ysyx_lsu_ctrl.sv
// Directed bench for ysyx_lsu_ctrl.
// Linear steps; expected values are hand-computed constants.
module tb_ysyx_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready_o;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_ren;
  logic        in_wen;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        out_valid_o;
  logic        out_ready;
  logic [31:0] out_rdata_o;
  logic [4:0]  out_rd_o;
  logic        out_fault_o;
  logic [31:0] lsu_araddr_o;
  logic        lsu_arvalid_o;
  logic [7:0]  lsu_rstrb_o;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr_o;
  logic        lsu_awvalid_o;
  logic [31:0] lsu_wdata_o;
  logic [7:0]  lsu_wstrb_o;
  logic        lsu_wvalid_o;
  logic        lsu_wready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_lsu_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready_o   (in_ready_o),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_ren       (in_ren),
    .in_wen       (in_wen),
    .in_funct3    (in_funct3),
    .in_rd        (in_rd),
    .out_valid_o  (out_valid_o),
    .out_ready    (out_ready),
    .out_rdata_o  (out_rdata_o),
    .out_rd_o     (out_rd_o),
    .out_fault_o  (out_fault_o),
    .lsu_araddr_o (lsu_araddr_o),
    .lsu_arvalid_o(lsu_arvalid_o),
    .lsu_rstrb_o  (lsu_rstrb_o),
    .lsu_rdata    (lsu_rdata),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_awaddr_o (lsu_awaddr_o),
    .lsu_awvalid_o(lsu_awvalid_o),
    .lsu_wdata_o  (lsu_wdata_o),
    .lsu_wstrb_o  (lsu_wstrb_o),
    .lsu_wvalid_o (lsu_wvalid_o),
    .lsu_wready   (lsu_wready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic ren,
                     input logic wen,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [4:0] rd);
    in_valid  = 1'b1;
    in_ren    = ren;
    in_wen    = wen;
    in_funct3 = f3;
    in_addr   = a;
    in_wdata  = d;
    in_rd     = rd;
    chk("req_ready", {31'd0, in_ready_o}, 32'd1);
    step();
    in_valid = 1'b0;
    in_ren   = 1'b0;
    in_wen   = 1'b0;
  endtask

  task automatic resp_done();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("exit_ovalid", {31'd0, out_valid_o}, 32'd0);
    chk("exit_iready", {31'd0, in_ready_o}, 32'd1);
  endtask

  task automatic fault_case(input string tag,
                            input logic ren,
                            input logic wen,
                            input logic [2:0] f3,
                            input logic [31:0] a,
                            input logic exp_f);
    req(ren, wen, f3, a, 32'h1111_2222, 5'd3);
    chk({tag, "_ov"}, {31'd0, out_valid_o}, 32'd1);
    chk({tag, "_flt"}, {31'd0, out_fault_o},
        {31'd0, exp_f});
    chk({tag, "_ar"}, {31'd0, lsu_arvalid_o}, 32'd0);
    chk({tag, "_aw"}, {31'd0, lsu_awvalid_o}, 32'd0);
    chk({tag, "_rd0"}, out_rdata_o, 32'd0);
    resp_done();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_wdata   = '0;
    in_ren     = 1'b0;
    in_wen     = 1'b0;
    in_funct3  = '0;
    in_rd      = '0;
    out_ready  = 1'b0;
    lsu_rdata  = '0;
    lsu_rvalid = 1'b0;
    lsu_wready = 1'b0;

    step();
    step();
    chk("rst_iready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_ovalid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_rdata", out_rdata_o, 32'd0);
    chk("rst_rd", {27'd0, out_rd_o}, 32'd0);
    chk("rst_fault", {31'd0, out_fault_o}, 32'd0);
    chk("rst_ar", {31'd0, lsu_arvalid_o}, 32'd0);
    chk("rst_aw", {31'd0, lsu_awvalid_o}, 32'd0);
    chk("rst_w", {31'd0, lsu_wvalid_o}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_iready", {31'd0, in_ready_o}, 32'd1);

    // LB with 3 wait cycles; stray wready must be ignored
    req(1'b1, 1'b0, 3'b000, 32'h8000_0003,
        32'h0, 5'd5);
    lsu_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lb_ar", {31'd0, lsu_arvalid_o}, 32'd1);
      chk("lb_addr", lsu_araddr_o, 32'h8000_0003);
      chk("lb_strb", {24'd0, lsu_rstrb_o}, 32'h01);
      chk("lb_aw", {31'd0, lsu_awvalid_o}, 32'd0);
      chk("lb_iready", {31'd0, in_ready_o}, 32'd0);
      chk("lb_ov", {31'd0, out_valid_o}, 32'd0);
      if (i == 3) begin
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h80FF_FF12;
      end
      step();
    end
    lsu_wready = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = 32'h0;
    chk("lb_ar_off", {31'd0, lsu_arvalid_o}, 32'd0);
    chk("lb_ov", {31'd0, out_valid_o}, 32'd1);
    chk("lb_data", out_rdata_o, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, out_rd_o}, 32'd5);
    chk("lb_flt", {31'd0, out_fault_o}, 32'd0);
    resp_done();

    // LHU, immediate response, then 5-cycle WBU stall
    req(1'b1, 1'b0, 3'b101, 32'h8000_0002,
        32'h0, 5'd7);
    chk("lhu_ar", {31'd0, lsu_arvalid_o}, 32'd1);
    chk("lhu_strb", {24'd0, lsu_rstrb_o}, 32'h03);
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'hBEEF_1234;
    step();
    lsu_rvalid = 1'b0;
    lsu_rdata  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      lsu_rvalid = (i == 2);
      lsu_rdata  = 32'h5555_5555;
      chk("stall_ov", {31'd0, out_valid_o}, 32'd1);
      chk("stall_data", out_rdata_o, 32'h0000_BEEF);
      chk("stall_rd", {27'd0, out_rd_o}, 32'd7);
      chk("stall_iready", {31'd0, in_ready_o}, 32'd0);
      step();
    end
    lsu_rvalid = 1'b0;
    chk("lhu_data", out_rdata_o, 32'h0000_BEEF);
    resp_done();

    // SW with wready after 2 wait cycles
    req(1'b0, 1'b1, 3'b010, 32'h8000_0010,
        32'hDEAD_BEEF, 5'd9);
    for (int i = 0; i < 3; i++) begin
      chk("sw_aw", {31'd0, lsu_awvalid_o}, 32'd1);
      chk("sw_w", {31'd0, lsu_wvalid_o}, 32'd1);
      chk("sw_addr", lsu_awaddr_o, 32'h8000_0010);
      chk("sw_data", lsu_wdata_o, 32'hDEAD_BEEF);
      chk("sw_strb", {24'd0, lsu_wstrb_o}, 32'h0f);
      chk("sw_ar", {31'd0, lsu_arvalid_o}, 32'd0);
      chk("sw_ov", {31'd0, out_valid_o}, 32'd0);
      if (i == 2)
        lsu_wready = 1'b1;
      step();
    end
    lsu_wready = 1'b0;
    chk("sw_aw_off", {31'd0, lsu_awvalid_o}, 32'd0);
    chk("sw_w_off", {31'd0, lsu_wvalid_o}, 32'd0);
    chk("sw_ov", {31'd0, out_valid_o}, 32'd1);
    chk("sw_rdata", out_rdata_o, 32'd0);
    chk("sw_rd", {27'd0, out_rd_o}, 32'd9);
    chk("sw_flt", {31'd0, out_fault_o}, 32'd0);
    resp_done();

    // SB strobe
    req(1'b0, 1'b1, 3'b000, 32'h8000_0021,
        32'h0000_00AB, 5'd1);
    chk("sb_strb", {24'd0, lsu_wstrb_o}, 32'h01);
    lsu_wready = 1'b1;
    step();
    lsu_wready = 1'b0;
    chk("sb_ov", {31'd0, out_valid_o}, 32'd1);
    resp_done();

    // Fault and no-op requests
    fault_case("lw_mis", 1'b1, 1'b0, 3'b010,
               32'h8000_0002, 1'b1);
    fault_case("lh_mis", 1'b1, 1'b0, 3'b001,
               32'h8000_0001, 1'b1);
    fault_case("sh_mis", 1'b0, 1'b1, 3'b001,
               32'h8000_0003, 1'b1);
    fault_case("st_f3", 1'b0, 1'b1, 3'b100,
               32'h8000_0000, 1'b1);
    fault_case("ld_f3", 1'b1, 1'b0, 3'b011,
               32'h8000_0000, 1'b1);
    fault_case("both", 1'b1, 1'b1, 3'b000,
               32'h8000_0000, 1'b1);
    fault_case("noop", 1'b0, 1'b0, 3'b010,
               32'h8000_0000, 1'b0);

    // Reset in the middle of a load
    req(1'b1, 1'b0, 3'b010, 32'h8000_0040,
        32'h0, 5'd4);
    chk("rr_ar", {31'd0, lsu_arvalid_o}, 32'd1);
    rst = 1'b1;
    step();
    chk("rr_ar_off", {31'd0, lsu_arvalid_o}, 32'd0);
    chk("rr_ov", {31'd0, out_valid_o}, 32'd0);
    chk("rr_rd", {27'd0, out_rd_o}, 32'd0);
    rst = 1'b0;
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_ov_after", {31'd0, out_valid_o}, 32'd0);
      chk("rr_iready", {31'd0, in_ready_o}, 32'd1);
      chk("rr_ar_after", {31'd0, lsu_arvalid_o}, 32'd0);
    end
    lsu_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
